// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg
//   Constants and types shared by the slot sequencer, its bus interface and
//   the 10-way slot multiplexer it drives.
//   NUM_SLOTS : slots scanned per frame
//   SEL_W     : select / slot-index width (also the multiplexer select width)
//   DATA_W    : slot data width
//   DWELL_W   : dwell-count width
package mux_seq_pkg;

    localparam int NUM_SLOTS = 10;
    localparam int SEL_W     = 4;
    localparam int DATA_W    = 16;
    localparam int DWELL_W   = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mux_sel_seq_if.sv
// mux_sel_seq_if
//   Control, multiplexer and sample bus of the slot sequencer.
//   slave  : sequencer side (takes start/stop/loop_en/dwell/slot_data,
//            drives mux_sel/busy/sample_*/frame_done)
//   master : controller / multiplexer side (the opposite directions)
interface mux_sel_seq_if;
    import mux_seq_pkg::*;

    logic               start;
    logic               stop;
    logic               loop_en;
    logic [DWELL_W-1:0] dwell;
    logic [DATA_W-1:0]  slot_data;
    logic [SEL_W-1:0]   mux_sel;
    logic               busy;
    logic               sample_valid;
    logic [DATA_W-1:0]  sample_data;
    logic [SEL_W-1:0]   sample_slot;
    logic               frame_done;

    modport slave (
        input  start, stop, loop_en, dwell, slot_data,
        output mux_sel, busy, sample_valid, sample_data, sample_slot, frame_done
    );

    modport master (
        output start, stop, loop_en, dwell, slot_data,
        input  mux_sel, busy, sample_valid, sample_data, sample_slot, frame_done
    );

endinterface

// File: rtl/mux_sel_seq.sv
// mux_sel_seq
//   Steps the slot multiplexer select through slots 0..NUM_SLOTS-1, holding
//   each slot for dwell_q cycles, and captures the multiplexer output on the
//   last dwell cycle of each slot as a tagged one-cycle sample.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mux_sel_seq_if.slave
//            start/stop/loop_en/dwell  frame control
//            slot_data                 multiplexer output (combinational of mux_sel)
//            mux_sel                   registered multiplexer select
//            busy                      high while scanning
//            sample_valid/_data/_slot  one-cycle tagged sample
//            frame_done                strobe with the last-slot sample
module mux_sel_seq
    import mux_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mux_sel_seq_if.slave bus
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_SLOTS - 1);

    // A zero dwell would never reach its last cycle; treat it as one cycle.
    function automatic logic [DWELL_W-1:0] dwell_sat(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    state_t             state_q, state_n;
    logic [DWELL_W-1:0] cnt_q, cnt_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic [SEL_W-1:0]   sel_q, sel_n;
    logic               vld_p0, vld_n;
    logic [DATA_W-1:0]  data_p0, data_n;
    logic [SEL_W-1:0]   slot_p0, slot_n;
    logic               fd_p0, fd_n;
    logic               last_dwell;

    assign last_dwell = (cnt_q == dwell_q - DWELL_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dwell_q <= DWELL_W'(1);
            sel_q   <= '0;
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            slot_p0 <= '0;
            fd_p0   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            dwell_q <= dwell_n;
            sel_q   <= sel_n;
            vld_p0  <= vld_n;
            data_p0 <= data_n;
            slot_p0 <= slot_n;
            fd_p0   <= fd_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        dwell_n = dwell_q;
        sel_n   = sel_q;
        vld_n   = 1'b0;
        fd_n    = 1'b0;
        data_n  = data_p0;
        slot_n  = slot_p0;

        unique case (state_q)
            IDLE: begin
                cnt_n = '0;
                sel_n = '0;
                if (bus.start && !bus.stop) begin
                    state_n = RUN;
                    dwell_n = dwell_sat(bus.dwell);
                end
            end
            RUN: begin
                if (bus.stop) begin
                    // Abort drops any sample due on this edge.
                    state_n = IDLE;
                    cnt_n   = '0;
                    sel_n   = '0;
                end else if (last_dwell) begin
                    cnt_n  = '0;
                    vld_n  = 1'b1;
                    data_n = bus.slot_data;
                    slot_n = sel_q;
                    if (sel_q == LAST_SLOT) begin
                        fd_n  = 1'b1;
                        sel_n = '0;
                        if (!bus.loop_en) state_n = IDLE;
                    end else begin
                        sel_n = sel_q + SEL_W'(1);
                    end
                end else begin
                    cnt_n = cnt_q + DWELL_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.mux_sel      = sel_q;
    assign bus.busy         = (state_q == RUN);
    assign bus.sample_valid = vld_p0;
    assign bus.sample_data  = data_p0;
    assign bus.sample_slot  = slot_p0;
    assign bus.frame_done   = fd_p0;

endmodule

// File: doc/mux_sel_seq.md
# mux_sel_seq

Slot sequencer that sits directly upstream of the 10-way 16-bit slot multiplexer. It drives the multiplexer's 4-bit select through slots 0..9 and holds each slot for a programmable dwell time. It captures the multiplexer output at the end of each dwell and presents it as a tagged one-cycle sample to the downstream logic. Supports single-frame and continuous-loop operation, with an abort via stop.

## Interface
- NUM_SLOTS, 10, number of multiplexer slots scanned per frame
- SEL_W, 4, select/slot-index width
- DATA_W, 16, slot data width
- DWELL_W, 16, dwell-count width
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a frame; honoured only in IDLE
- stop  input  1  abort scan; honoured in RUN; wins over start
- loop_en  input  1  sampled at end of slot 9: 1 = restart at slot 0, 0 = return to IDLE
- dwell  input  DWELL_W  cycles per slot; latched on accepted start; 0 treated as 1
- slot_data  input  DATA_W  multiplexer output (combinational from mux_sel)
- mux_sel  output  SEL_W  registered select to the multiplexer
- busy  output  1  high while in RUN
- sample_valid  output  1  one-cycle strobe, sample_data/sample_slot valid
- sample_data  output  DATA_W  captured slot_data
- sample_slot  output  SEL_W  slot index the sample came from
- frame_done  output  1  one-cycle strobe coincident with the slot-9 sample

## Operation
- States: IDLE, RUN.
- IDLE: mux_sel=0, busy=0, counter=0. start=1 and stop=0 → RUN; dwell_q ← max(dwell,1), slot=0.
- RUN: the counter increments each cycle. When counter == dwell_q-1 (last dwell cycle):
  - sample_data ← slot_data, sample_slot ← mux_sel, sample_valid ← 1, counter ← 0.
  - If mux_sel < 9: mux_sel ← mux_sel+1.
  - If mux_sel == 9: frame_done ← 1. If loop_en=1, mux_sel ← 0 and stay in RUN. Otherwise go to IDLE with mux_sel ← 0.
- stop=1 in RUN → IDLE at the next edge. mux_sel ← 0, counter ← 0. No sample or frame_done is produced on that edge, even if it was a last-dwell cycle.
- start in RUN is ignored. start and stop together in IDLE leave the block in IDLE.
- dwell changes during RUN have no effect until the next accepted start; loop restarts reuse dwell_q.
- sample_data/sample_slot hold their last value when sample_valid=0.
- Counter never exceeds dwell_q-1; mux_sel never exceeds NUM_SLOTS-1 (values 10..15 unreachable).

## Timing
- Reset: state IDLE. mux_sel=0, busy=0, sample_valid=0, sample_data=0, sample_slot=0, frame_done=0. counter=0, dwell_q=1.
- Let E0 be the edge accepting start, and D = dwell_q. busy=1 from E0. Slot k is selected during cycles E0+k·D .. E0+(k+1)·D-1.
- Sample for slot k is registered at edge E0+(k+1)·D. sample_valid is high for exactly the following cycle.
- frame_done is registered at edge E0+10·D. Without loop, busy=0 from that same edge.
- With loop, slot 0 follows slot 9 with no gap: D=1 gives a continuous sample_valid.
- Input-to-effect latency for start, stop and loop_en: one edge.

## Structure
- Shared package mux_seq_pkg holds:
  - NUM_SLOTS, SEL_W, DATA_W and DWELL_W constants, shared with the multiplexer's select width.
  - The state enum {IDLE, RUN}.
- Single module with no sub-module. The dwell counter and slot counter are inline registers.

## Test plan
- Reset mid-RUN (rst at slot 4) → next cycle all outputs at reset values, IDLE; a following start begins at slot 0.
- dwell=3, loop_en=0, slot_data = 16'hA000+slot, start → 10 sample_valid pulses 3 cycles apart. sample_slot 0..9, sample_data A000..A009. frame_done only with the A009 sample; busy falls at the same edge. Total 30 cycles.
- dwell=0 with loop_en=1 → behaves as dwell=1. sample_valid high every cycle, sample_slot wraps 9→0, frame_done every 10th cycle.
- stop asserted on the last dwell cycle of slot 5 (dwell=4) → no slot-5 sample, IDLE next edge, mux_sel=0.
- start+stop together in IDLE → stays IDLE. start during RUN → no restart, sequence unchanged.
- dwell changed from 2 to 7 mid-frame with loop_en=1 → all slots, including after the loop wrap, still dwell 2 cycles.
